seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 22 ++
 rtl/hex_to_seg7.sv | 10 +
 rtl/seg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SCAN  = 1'b1
   } state_t;

   localparam int NUM_DIGITS = 4;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [3:0] AN_PATTERN [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} codes for 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7 (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   import seg_pkg::*;

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller with frame-aligned reloads.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always shown).
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_en,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [3:0]  an,
   output logic [3:0]  hex_num,
   output logic [6:0]  seg,
   output logic        frame_done
);
   import seg_pkg::*;

   localparam int              CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [15:0]      disp, disp_nxt;
   logic [15:0]      pend, pend_nxt;
   logic             pend_valid, pend_valid_nxt;
   logic             scanning, tick, frame_end, xfer, digit_blank;
   logic [6:0]       seg_raw;

   assign scanning   = (state == SCAN) && scan_en;
   assign tick       = scanning && (count == CNT_MAX);
   assign frame_end  = tick && (idx == 2'(NUM_DIGITS - 1));
   assign load_ready = !pend_valid;
   assign xfer       = load_valid && load_ready;

   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      idx_nxt        = idx;
      disp_nxt       = disp;
      pend_nxt       = pend;
      pend_valid_nxt = pend_valid;
      case (state)
         BLANK: begin
            if (xfer) begin
               disp_nxt  = load_data;
               state_nxt = SCAN;
               count_nxt = '0;
               idx_nxt   = '0;
            end
         end
         SCAN: begin
            if (!scan_en) begin
               count_nxt = '0;
               idx_nxt   = '0;
            end else if (tick) begin
               count_nxt = '0;
               idx_nxt   = idx + 2'd1;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
            // Pending value only lands between frames (or while the display is off) to avoid tearing
            if (pend_valid && (!scan_en || frame_end)) begin
               disp_nxt       = pend;
               pend_valid_nxt = 1'b0;
            end else if (xfer) begin
               pend_nxt       = load_data;
               pend_valid_nxt = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BLANK;
         count      <= '0;
         idx        <= '0;
         disp       <= '0;
         pend_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         idx        <= idx_nxt;
         disp       <= disp_nxt;
         pend_valid <= pend_valid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      pend <= pend_nxt;
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   always_comb begin
      case (idx)
         2'd1:    digit_blank = (disp[15:4]  == 12'h000);
         2'd2:    digit_blank = (disp[15:8]  == 8'h00);
         2'd3:    digit_blank = (disp[15:12] == 4'h0);
         default: digit_blank = 1'b0;
      endcase
   end
`else
   assign digit_blank = 1'b0;
`endif

   assign an         = (scanning && !digit_blank) ? AN_PATTERN[idx] : AN_OFF;
   assign hex_num    = (state == SCAN) ? disp[{idx, 2'b00} +: 4] : 4'h0;
   assign frame_done = frame_end;

   hex_to_seg7 u_dec (
      .hex (hex_num),
      .seg (seg_raw)
   );

   assign seg = (an == AN_OFF) ? SEG_OFF : seg_raw;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at REFRESH_DIV=4; honours SEG_LEADING_ZERO_BLANK_EN.
module tb_seg_scan_ctrl;

   localparam int RD = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_en = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic        load_ready, frame_done;
   logic [3:0]  an, hex_num;
   logic [6:0]  seg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .an         (an),
      .hex_num    (hex_num),
      .seg        (seg),
      .frame_done (frame_done)
   );

   typedef struct {
      logic        sen;
      logic        lv;
      logic [15:0] ld;
      logic [3:0]  an;
      logic [3:0]  hex;
      logic [6:0]  seg;
      logic        rdy;
      logic        fd;
   } vec_t;

   vec_t tbl [18];

   function automatic logic [6:0] seg_of(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] v, input int i);
      return v[4*i +: 4];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Expected outputs for position p (0..15) of a frame showing val
   task automatic chk_slot(input string tag, input logic [15:0] val, input int p);
      int         i;
      bit         blank;
      logic [3:0] ean;
      logic [3:0] h;
      logic [6:0] es;
      i     = (p / 4) % 4;
      blank = LZ && (i >= 1) && ((val >> (4 * i)) == 16'h0);
      h     = nib(val, i);
      ean   = ~(4'b0001 << i);
      if (blank) begin
         ean = 4'hF;
         es  = 7'h7F;
      end else begin
         es  = seg_of(h);
         chk({tag, " hex"}, {12'h0, hex_num}, {12'h0, h});
      end
      chk({tag, " an"}, {12'h0, an}, {12'h0, ean});
      chk({tag, " seg"}, {9'h0, seg}, {9'h0, es});
      chk({tag, " frame_done"}, {15'h0, frame_done}, {15'h0, logic'(p % 16 == 15)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] dig [4];
      logic [6:0] sg  [4];
      logic [3:0] anp [4];
      dig = '{4'h4, 4'h3, 4'h2, 4'h1};
      sg  = '{7'h19, 7'h30, 7'h24, 7'h79};
      anp = '{4'hE, 4'hD, 4'hB, 4'h7};
      tbl[0] = '{1'b1, 1'b1, 16'h1234, 4'hF, 4'h0, 7'h7F, 1'b1, 1'b0};
      for (int p = 0; p < 17; p++) begin
         tbl[p+1] = '{1'b1, 1'b0, 16'h0, anp[(p/4)%4], dig[(p/4)%4], sg[(p/4)%4], 1'b1, logic'(p == 15)};
      end

      // reset state
      scan_en = 1'b1;
      step;
      step;
      chk("rst an", {12'h0, an}, 16'h000F);
      chk("rst seg", {9'h0, seg}, 16'h007F);
      chk("rst hex", {12'h0, hex_num}, 16'h0);
      chk("rst ready", {15'h0, load_ready}, 16'h1);
      chk("rst frame_done", {15'h0, frame_done}, 16'h0);
      rst_n = 1'b1;
      step;
      chk("blank idle an", {12'h0, an}, 16'h000F);

      // scan test from the table
      for (int v = 0; v < 18; v++) begin
         scan_en    = tbl[v].sen;
         load_valid = tbl[v].lv;
         load_data  = tbl[v].ld;
         #1;
         chk($sformatf("vec%0d an", v), {12'h0, an}, {12'h0, tbl[v].an});
         chk($sformatf("vec%0d hex", v), {12'h0, hex_num}, {12'h0, tbl[v].hex});
         chk($sformatf("vec%0d seg", v), {9'h0, seg}, {9'h0, tbl[v].seg});
         chk($sformatf("vec%0d ready", v), {15'h0, load_ready}, {15'h0, tbl[v].rdy});
         chk($sformatf("vec%0d frame_done", v), {15'h0, frame_done}, {15'h0, tbl[v].fd});
         step;
      end

      // mid-frame load at position 1; second offer held off until the frame ends
      load_valid = 1'b1;
      load_data  = 16'hABCD;
      #1;
      chk("mf ready first", {15'h0, load_ready}, 16'h1);
      chk_slot("mf old", 16'h1234, 1);
      step;
      load_data = 16'h5678;
      for (int p = 2; p < 16; p++) begin
         chk("mf ready held", {15'h0, load_ready}, 16'h0);
         chk_slot("mf old", 16'h1234, p);
         step;
      end
      chk("mf ready back", {15'h0, load_ready}, 16'h1);
      chk_slot("mf new", 16'hABCD, 0);
      step;
      load_valid = 1'b0;
      chk("mf second accepted", {15'h0, load_ready}, 16'h0);
      for (int p = 1; p < 10; p++) begin
         chk_slot("mf new", 16'hABCD, p);
         if (p < 9) step;
      end

      // drop enable mid digit 2
      scan_en = 1'b0;
      #1;
      chk("en off an", {12'h0, an}, 16'h000F);
      chk("en off frame_done", {15'h0, frame_done}, 16'h0);
      step;
      chk("en off next an", {12'h0, an}, 16'h000F);
      chk("en off seg", {9'h0, seg}, 16'h007F);
      chk("en off commit ready", {15'h0, load_ready}, 16'h1);
      chk("en off commit hex", {12'h0, hex_num}, 16'h0008);
      step;
      chk("en off held an", {12'h0, an}, 16'h000F);
      scan_en = 1'b1;
      #1;
      for (int p = 0; p < 16; p++) begin
         chk_slot("en resume", 16'h5678, p);
         step;
      end

      // reset with a pending value
      load_valid = 1'b1;
      load_data  = 16'hEEEE;
      step;
      load_valid = 1'b0;
      chk("pre-rst ready", {15'h0, load_ready}, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst an", {12'h0, an}, 16'h000F);
      chk("async rst seg", {9'h0, seg}, 16'h007F);
      chk("async rst hex", {12'h0, hex_num}, 16'h0);
      chk("async rst ready", {15'h0, load_ready}, 16'h1);
      chk("async rst frame_done", {15'h0, frame_done}, 16'h0);
      step;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step;
         chk("post-rst blank an", {12'h0, an}, 16'h000F);
         chk("post-rst blank hex", {12'h0, hex_num}, 16'h0);
      end
      load_valid = 1'b1;
      load_data  = 16'h4321;
      step;
      load_valid = 1'b0;
      for (int p = 0; p < 16; p++) begin
         chk_slot("post-rst", 16'h4321, p);
         step;
      end

      // leading-zero handling
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      step;
      load_valid = 1'b1;
      load_data  = 16'h0050;
      step;
      load_valid = 1'b0;
      for (int p = 0; p < 16; p++) begin
         chk_slot("lz 0050", 16'h0050, p);
         step;
      end
      load_valid = 1'b1;
      load_data  = 16'h0000;
      #1;
      for (int p = 0; p < 16; p++) begin
         chk_slot("lz 0050 hold", 16'h0050, p);
         step;
         load_valid = 1'b0;
      end
      for (int p = 0; p < 16; p++) begin
         chk_slot("lz 0000", 16'h0000, p);
         step;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
